csr_file: RTL
=============

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter MHARTID, 32'd0, value returned by mhartid (0xF14).
REQ-002 Parameter MTVEC_RESET, 32'h0000_0000, mtvec reset value; bits [1:0] are ignored and read as 0.
REQ-003 Parameter COUNTERS_EN, 1, 1 implements mcycle/minstret (and high halves); 0 makes those addresses illegal.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 csr_en  in  1  CSR instruction valid this cycle.
REQ-007 csr_adr  in  12  CSR address.
REQ-008 csr_op_ctr  in  2  0=RW, 1=RS, 2=RC, 3=reserved.
REQ-009 csr_wdata_i  in  32  rs1 data or zero-extended uimm.
REQ-010 csr_wr_suppress  in  1  rs1/uimm field is zero on RS/RC; no write occurs.
REQ-011 instret_i  in  1  one instruction retired this cycle.
REQ-012 trap_i, trap_pc_i[31:0], trap_cause_i[31:0]  in  trap entry request, faulting PC, cause.
REQ-013 mret_i  in  1  MRET executed.
REQ-014 csr_rdata_o  out  32  current (pre-write) value of csr_adr, combinational.
REQ-015 illegal_csr  out  1  access illegal, combinational, qualified by csr_en.
REQ-016 mtvec_o, mepc_o  out  32  current mtvec and mepc.
REQ-017 mie_o  out  1  current mstatus.MIE.

Function
REQ-018 Implemented CSRs: misa 0x301 = 32'h4000_0100 (RO); mvendorid 0xF11, marchid 0xF12, mimpid 0xF13 = 0 (RO); mhartid 0xF14 (RO); mstatus 0x300; mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342; mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
REQ-019 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
REQ-020 mepc bits [1:0] are forced to 0 on every write.
REQ-021 Written value: RW = wdata; RS = old | wdata; RC = old & ~wdata; old = csr_rdata_o.
REQ-022 Write is effective when csr_en & !illegal_csr & !(op in {RS,RC} & csr_wr_suppress); it commits at the next rising edge; RW always writes.
REQ-023 illegal_csr = csr_en & (unimplemented address | op==3 | (csr_adr[11:10]==2'b11 & effective write attempted)).
REQ-024 An illegal access changes no state; csr_rdata_o is 0 for unimplemented addresses.
REQ-025 mcycle increments by 1 every cycle not in reset; minstret increments by 1 when instret_i=1; both are 64-bit and wrap from 2^64-1 to 0.
REQ-026 A CSR write to either half of a counter replaces that half and suppresses that counter's increment for that cycle; the other half is held.
REQ-027 Carry from low to high half occurs in the same cycle as the low-half wrap.
REQ-028 trap_i: mepc <= trap_pc_i & ~3, mcause <= trap_cause_i, MPIE <= MIE, MIE <= 0, all at the next edge.
REQ-029 mret_i: MIE <= MPIE, MPIE <= 1.
REQ-030 Priority for mstatus/mepc/mcause: trap_i > mret_i > CSR write; the losing CSR write is dropped, but illegal_csr is still reported.
REQ-031 Counters are unaffected by trap_i and mret_i.

Reset
REQ-032 When rst=1 at an edge: mstatus MIE=0 and MPIE=0; mtvec=MTVEC_RESET & ~3; mscratch, mepc, mcause=0; all counters=0.
REQ-033 rst overrides csr_en, trap_i, mret_i and counter increment in the same cycle; mcycle reads 0 in the first cycle after reset deassertion.
REQ-034 Combinational outputs track register state during reset; illegal_csr depends only on inputs.

Structure
REQ-035 Package csr_pkg holds the CSR address localparams, the csr_op_e enum (RW/RS/RC/RSVD), mstatus bit positions, and the MISA_RV32I constant.
REQ-036 One sub-module, csr_counter64 (inc, wr_lo, wr_hi, wdata; 64-bit count), instanced for mcycle and minstret under generate on COUNTERS_EN.

Verification
REQ-037 Reset, then RW 0x340 with 0xDEAD_BEEF, then read -> 0xDEAD_BEEF; the read in the write cycle returns 0.
REQ-038 RS 0x300 with 0x8, then RC 0x300 with 0x8 -> reads 0x1808 then 0x1800; RS with csr_wr_suppress=1 -> no change, illegal_csr=0.
REQ-039 RW 0xF11 -> illegal_csr=1, no state change; RS 0xF11 with suppress=1 -> legal read 0; op=3 on 0x340 -> illegal; address 0x7C0 -> illegal, rdata 0.
REQ-040 MIE=1, trap_i with pc 0x1003, cause 0xB, plus RW 0x341 0x55 in the same cycle -> mepc=0x1000, mcause=0xB, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
REQ-041 RW 0xB00 with 0xFFFF_FFFF, 0xB80 with 0xFFFF_FFFF, then idle -> the next cycle wraps to 0/0; minstret counts exactly the number of instret_i pulses.
REQ-042 COUNTERS_EN=0 -> 0xB00 illegal; MTVEC_RESET=0x8000_0103 -> mtvec_o=0x8000_0100 after reset.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, access ops,
// mstatus layout and the read-only identification constants.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      RW   = 2'd0,
      RS   = 2'd1,
      RC   = 2'd2,
      RSVD = 2'd3
   } csr_op_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

   // MPP is hardwired to machine mode; only MIE and MPIE carry state.
   function automatic logic [31:0] mstatus_read(logic mie, logic mpie);
      logic [31:0] v;
      v                = '0;
      v[12:11]         = 2'b11;
      v[MSTATUS_MPIE]  = mpie;
      v[MSTATUS_MIE]   = mie;
      return v;
   endfunction

   function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] old_val,
                                                logic [31:0] wdata);
      case (op)
         RW:      return wdata;
         RS:      return old_val | wdata;
         RC:      return old_val & ~wdata;
         default: return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR instruction port between the execute stage (master) and the CSR file (slave).
interface csr_file_if;
   logic        csr_en;
   logic [11:0] csr_adr;
   logic [1:0]  csr_op_ctr;
   logic [31:0] csr_wdata_i;
   logic        csr_wr_suppress;
   logic [31:0] csr_rdata_o;
   logic        illegal_csr;

   modport master (
      output csr_en, csr_adr, csr_op_ctr, csr_wdata_i, csr_wr_suppress,
      input  csr_rdata_o, illegal_csr
   );

   modport slave (
      input  csr_en, csr_adr, csr_op_ctr, csr_wdata_i, csr_wr_suppress,
      output csr_rdata_o, illegal_csr
   );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a write to either half suppresses that cycle's increment.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (wr_lo) begin
         count[31:0] <= wdata;
      end else if (wr_hi) begin
         count[63:32] <= wdata;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: RW/RS/RC access, trap entry / MRET bookkeeping and
// optional mcycle/minstret counters.
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] MHARTID     = 32'd0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter bit          COUNTERS_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   csr_file_if.slave   bus,
   input  logic        instret_i,
   input  logic        trap_i,
   input  logic [31:0] trap_pc_i,
   input  logic [31:0] trap_cause_i,
   input  logic        mret_i,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        mie_o
);

   logic        mie_q, mpie_q;
   logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [63:0] mcycle, minstret;

   csr_op_e     op;
   logic        implemented;
   logic        wr_attempt;
   logic        wr_en;
   logic [31:0] rdata;
   logic [31:0] wval;

   assign op = csr_op_e'(bus.csr_op_ctr);

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      rdata       = '0;
      implemented = 1'b1;
      case (bus.csr_adr)
         CSR_MISA:      rdata = MISA_RV32I;
         CSR_MVENDORID,
         CSR_MARCHID,
         CSR_MIMPID:    rdata = '0;
         CSR_MHARTID:   rdata = MHARTID;
         CSR_MSTATUS:   rdata = mstatus_read(mie_q, mpie_q);
         CSR_MTVEC:     rdata = mtvec_q;
         CSR_MSCRATCH:  rdata = mscratch_q;
         CSR_MEPC:      rdata = mepc_q;
         CSR_MCAUSE:    rdata = mcause_q;
         CSR_MCYCLE:    if (COUNTERS_EN) rdata = mcycle[31:0];    else implemented = 1'b0;
         CSR_MCYCLEH:   if (COUNTERS_EN) rdata = mcycle[63:32];   else implemented = 1'b0;
         CSR_MINSTRET:  if (COUNTERS_EN) rdata = minstret[31:0];  else implemented = 1'b0;
         CSR_MINSTRETH: if (COUNTERS_EN) rdata = minstret[63:32]; else implemented = 1'b0;
         default:       implemented = 1'b0;
      endcase
   end

   // RS/RC with a zero source field are pure reads and may target read-only space.
   assign wr_attempt = (op == RW) || (((op == RS) || (op == RC)) && !bus.csr_wr_suppress);

   assign bus.illegal_csr = bus.csr_en &&
                            (!implemented || (op == RSVD) ||
                             ((bus.csr_adr[11:10] == 2'b11) && wr_attempt));

   assign wr_en       = bus.csr_en && !bus.illegal_csr && wr_attempt;
   assign wval        = csr_apply_op(op, rdata, bus.csr_wdata_i);
   assign bus.csr_rdata_o = rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & ~32'h3;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         if (wr_en && (bus.csr_adr == CSR_MTVEC))    mtvec_q    <= wval & ~32'h3;
         if (wr_en && (bus.csr_adr == CSR_MSCRATCH)) mscratch_q <= wval;

         // Trap entry and MRET own mstatus/mepc/mcause; a concurrent CSR write loses.
         if (trap_i) begin
            mepc_q   <= trap_pc_i & ~32'h3;
            mcause_q <= trap_cause_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end else if (wr_en) begin
            if (bus.csr_adr == CSR_MSTATUS) begin
               mie_q  <= wval[MSTATUS_MIE];
               mpie_q <= wval[MSTATUS_MPIE];
            end
            if (bus.csr_adr == CSR_MEPC)   mepc_q   <= wval & ~32'h3;
            if (bus.csr_adr == CSR_MCAUSE) mcause_q <= wval;
         end
      end
   end

   generate
      if (COUNTERS_EN) begin : g_counters
         csr_counter64 u_mcycle (
            .clk   (clk),
            .rst   (rst),
            .inc   (1'b1),
            .wr_lo (wr_en && (bus.csr_adr == CSR_MCYCLE)),
            .wr_hi (wr_en && (bus.csr_adr == CSR_MCYCLEH)),
            .wdata (wval),
            .count (mcycle)
         );
         csr_counter64 u_minstret (
            .clk   (clk),
            .rst   (rst),
            .inc   (instret_i),
            .wr_lo (wr_en && (bus.csr_adr == CSR_MINSTRET)),
            .wr_hi (wr_en && (bus.csr_adr == CSR_MINSTRETH)),
            .wdata (wval),
            .count (minstret)
         );
      end else begin : g_no_counters
         assign mcycle   = '0;
         assign minstret = '0;
      end
   endgenerate

   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;
   assign mie_o   = mie_q;

endmodule
